// File: rtl/instr_mem_pkg.sv
// Shared types for the instruction-memory arbiter: geometry defaults,
// response owner and the per-access read tag.
package instr_mem_pkg;

  localparam int IMEM_AW = 10;
  localparam int IMEM_DW = 32;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_LOAD  = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

endpackage

// File: rtl/imem_rd_tag_pipe.sv
// Delay line of read tags matching the memory read latency, so each
// returning word can be steered to the requester that issued it.
module imem_rd_tag_pipe
  import instr_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    clr,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '{valid: 1'b0, owner: OWN_FETCH};
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/instr_mem_arbiter.sv
// Shares one instruction-memory port between CPU fetch and the loader/debug
// port; loader wins, but never for more than MAX_RUN cycles while fetch waits.
module instr_mem_arbiter
  import instr_mem_pkg::*;
#(
  parameter int AW      = IMEM_AW,
  parameter int DW      = IMEM_DW,
  parameter int RD_LAT  = 1,
  parameter int MAX_RUN = 4
) (
  input  logic            clk_clk,
  input  logic            reset_reset,
  input  logic            f_req,
  input  logic [AW-1:0]   f_addr,
  output logic            f_ready,
  output logic            f_rvalid,
  output logic [DW-1:0]   f_rdata,
  input  logic            l_req,
  input  logic            l_we,
  input  logic [AW-1:0]   l_addr,
  input  logic [DW-1:0]   l_wdata,
  input  logic [DW/8-1:0] l_be,
  output logic            l_ready,
  output logic            l_rvalid,
  output logic [DW-1:0]   l_rdata,
  output logic [AW-1:0]   mem_address,
  output logic            mem_clken,
  output logic            mem_chipselect,
  output logic            mem_write,
  output logic [DW-1:0]   mem_writedata,
  output logic [DW/8-1:0] mem_byteenable,
  input  logic [DW-1:0]   mem_readdata
);

  localparam int CW = $clog2(MAX_RUN + 1);

  logic [CW-1:0] run_cnt;
  logic          grant_l;
  logic          grant_f;
  rd_tag_t       tag_in;
  rd_tag_t       tag_out;

  always_comb begin
    grant_l = 1'b0;
    grant_f = 1'b0;
    if (!reset_reset) begin
      grant_l = l_req && (!f_req || (run_cnt < CW'(MAX_RUN)));
      grant_f = f_req && !grant_l;
    end
  end

  assign f_ready = grant_f;
  assign l_ready = grant_l;

  // Grants are already forced low in reset, so every memory strobe follows.
  always_comb begin
    mem_chipselect = grant_l | grant_f;
    mem_write      = grant_l & l_we;
    mem_address    = '0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    if (grant_l) begin
      mem_address    = l_addr;
      mem_writedata  = l_wdata;
      mem_byteenable = l_be;
    end else if (grant_f) begin
      mem_address    = f_addr;
      mem_byteenable = '1;
    end
  end

  assign mem_clken = !reset_reset;

  // Counts loader wins only while fetch is actually waiting.
  always_ff @(posedge clk_clk) begin
    if (reset_reset || !f_req || grant_f) begin
      run_cnt <= '0;
    end else if (grant_l && (run_cnt < CW'(MAX_RUN))) begin
      run_cnt <= run_cnt + CW'(1);
    end
  end

  always_comb begin
    tag_in.valid = grant_f | (grant_l & !l_we);
    tag_in.owner = grant_l ? OWN_LOAD : OWN_FETCH;
  end

  imem_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk_clk),
    .clr     (reset_reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_comb begin
    f_rvalid = !reset_reset && tag_out.valid && (tag_out.owner == OWN_FETCH);
    l_rvalid = !reset_reset && tag_out.valid && (tag_out.owner == OWN_LOAD);
    f_rdata  = reset_reset ? '0 : mem_readdata;
    l_rdata  = reset_reset ? '0 : mem_readdata;
  end

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Bench for instr_mem_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_instr_mem_arbiter;

  localparam int AW      = 10;
  localparam int DW      = 32;
  localparam int RD_LAT  = 3;
  localparam int MAX_RUN = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req, l_req, l_we;
  logic [AW-1:0] f_addr, l_addr;
  logic [DW-1:0] l_wdata;
  logic [3:0]    l_be;
  logic          f_ready, f_rvalid, l_ready, l_rvalid;
  logic [DW-1:0] f_rdata, l_rdata;
  logic [AW-1:0] mem_address;
  logic          mem_clken, mem_chipselect, mem_write;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic [3:0]    mem_byteenable;

  always #5 clk = ~clk;

  instr_mem_arbiter #(
    .AW (AW), .DW (DW), .RD_LAT (RD_LAT), .MAX_RUN (MAX_RUN)
  ) dut (
    .clk_clk (clk), .reset_reset (rst),
    .f_req (f_req), .f_addr (f_addr), .f_ready (f_ready),
    .f_rvalid (f_rvalid), .f_rdata (f_rdata),
    .l_req (l_req), .l_we (l_we), .l_addr (l_addr), .l_wdata (l_wdata),
    .l_be (l_be), .l_ready (l_ready), .l_rvalid (l_rvalid), .l_rdata (l_rdata),
    .mem_address (mem_address), .mem_clken (mem_clken),
    .mem_chipselect (mem_chipselect), .mem_write (mem_write),
    .mem_writedata (mem_writedata), .mem_byteenable (mem_byteenable),
    .mem_readdata (mem_readdata)
  );

  // Memory slave with fixed read latency; preloads 0xA0+addr on the first edge.
  logic [DW-1:0] smem  [1024];
  logic [DW-1:0] spipe [RD_LAT];
  bit            loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) smem[i] <= 32'hA0 + i;
      loaded <= 1'b1;
    end else if (mem_chipselect && mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteenable[b]) smem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
    spipe[0] <= (mem_chipselect && !mem_write) ? smem[mem_address] : 32'hBAD0_0000;
    for (int i = 1; i < RD_LAT; i++) spipe[i] <= spipe[i-1];
  end
  assign mem_readdata = spipe[RD_LAT-1];

  // Reference model: pending responses as (due cycle, owner, data) records.
  typedef struct {
    int          due;
    bit          to_load;
    logic [31:0] data;
  } resp_t;

  resp_t       rq [$];
  logic [31:0] ref_mem [1024];
  int          run;
  int          cyc;
  int          n_cmp;
  int          n_err;
  bit          last_f;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model();
    bit    gl, gf, ef, el;
    resp_t r;
    cyc++;
    last_f = f_ready;
    if (rst) begin
      chk("rst_f_ready", f_ready, 0);
      chk("rst_l_ready", l_ready, 0);
      chk("rst_f_rvalid", f_rvalid, 0);
      chk("rst_l_rvalid", l_rvalid, 0);
      chk("rst_f_rdata", f_rdata, 0);
      chk("rst_l_rdata", l_rdata, 0);
      chk("rst_cs", mem_chipselect, 0);
      chk("rst_we", mem_write, 0);
      chk("rst_addr", mem_address, 0);
      chk("rst_wdata", mem_writedata, 0);
      chk("rst_be", mem_byteenable, 0);
      chk("rst_clken", mem_clken, 0);
      rq.delete();
      run = 0;
      return;
    end
    gl = l_req && (!f_req || run < MAX_RUN);
    gf = f_req && !gl;
    chk("f_ready", f_ready, gf);
    chk("l_ready", l_ready, gl);
    chk("clken", mem_clken, 1);
    chk("cs", mem_chipselect, gl || gf);
    chk("we", mem_write, gl && l_we);
    chk("addr", mem_address, gl ? l_addr : (gf ? f_addr : 0));
    chk("wdata", mem_writedata, gl ? l_wdata : 0);
    if (gl || gf) chk("be", mem_byteenable, gl ? l_be : 4'hF);

    ef = 0; el = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r  = rq.pop_front();
      ef = !r.to_load;
      el = r.to_load;
    end
    chk("f_rvalid", f_rvalid, ef);
    chk("l_rvalid", l_rvalid, el);
    if (ef) chk("f_rdata", f_rdata, r.data);
    if (el) chk("l_rdata", l_rdata, r.data);

    if (gf) rq.push_back('{due: cyc + RD_LAT, to_load: 1'b0, data: ref_mem[f_addr]});
    if (gl && !l_we) rq.push_back('{due: cyc + RD_LAT, to_load: 1'b1, data: ref_mem[l_addr]});
    if (gl && l_we)
      for (int b = 0; b < 4; b++)
        if (l_be[b]) ref_mem[l_addr][8*b +: 8] = l_wdata[8*b +: 8];

    if (!f_req || gf) run = 0;
    else if (gl) run = (run < MAX_RUN) ? run + 1 : MAX_RUN;
  endtask

  task automatic step();
    @(negedge clk);
    model();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit fr, input logic [AW-1:0] fa, input bit lr, input bit we,
                       input logic [AW-1:0] la, input logic [31:0] wd, input logic [3:0] be);
    f_req = fr; f_addr = fa; l_req = lr; l_we = we; l_addr = la; l_wdata = wd; l_be = be;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [9:0] fpat;

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; run = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hA0 + i;
    rst = 1;
    f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_be = 0;
    @(posedge clk); #1;
    idle(3);
    rst = 0;

    // fetch-only stream 0..3, then drain
    for (int a = 0; a < 4; a++) drive(1, AW'(a), 0, 0, 0, 0, 0);
    idle(RD_LAT + 1);

    // full write then fetch of the same word
    drive(0, 0, 1, 1, 10'h3FF, 32'hDEADBEEF, 4'hF);
    drive(1, 10'h3FF, 0, 0, 0, 0, 0);
    idle(RD_LAT + 1);

    // partial write over all-ones, loader read back
    drive(0, 0, 1, 1, 10'h010, 32'hFFFF_FFFF, 4'hF);
    drive(0, 0, 1, 1, 10'h010, 32'h0000_1234, 4'h3);
    drive(0, 0, 1, 0, 10'h010, 0, 0);
    idle(RD_LAT + 1);
    chk("partial_word", ref_mem[10'h010], 32'hFFFF_1234);

    // starvation bound: both requests held continuously
    fpat = '0;
    for (int i = 0; i < 10; i++) begin
      drive(1, AW'(i), 1, 0, AW'(20 + i), 0, 0);
      fpat[i] = last_f;
    end
    chk("starve_pattern", fpat, 10'b10_0001_0000);
    idle(RD_LAT + 1);

    // interleaved F, L read, L write, F
    drive(1, 10'h001, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 10'h002, 0, 0);
    drive(0, 0, 1, 1, 10'h003, 32'h5555_AAAA, 4'hF);
    drive(1, 10'h003, 0, 0, 0, 0, 0);
    idle(RD_LAT + 1);

    // reset with two reads in flight; fetch on the first cycle after release
    drive(1, 10'h004, 0, 0, 0, 0, 0);
    drive(1, 10'h005, 0, 0, 0, 0, 0);
    rst = 1;
    drive(1, 10'h006, 1, 0, 10'h007, 0, 0);
    rst = 0;
    drive(1, 10'h008, 0, 0, 0, 0, 0);
    idle(RD_LAT + 1);

    // random traffic on a small address window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 99) < 55), AW'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
    end
    rst = 0;
    idle(RD_LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
